// File: rtl/scan_pattern_sequencer.sv
// Scan-test driver: shifts one stimulus pattern into a scan chain, applies one capture
// clock, shifts the response back out, compares it and keeps a saturating failure count.
module scan_pattern_sequencer #(
   parameter int CHAIN_LEN = 3,
   parameter int CNT_W     = 8
) (
   input  logic                 Clk,
   input  logic                 Clr,
   input  logic                 Start,
   input  logic [CHAIN_LEN-1:0] Pattern,
   input  logic [CHAIN_LEN-1:0] Expect,
   input  logic                 tdo,
   output logic                 tms,
   output logic                 tdi,
   output logic                 Busy,
   output logic                 Done,
   output logic [CHAIN_LEN-1:0] Response,
   output logic                 Pass,
   output logic [CNT_W-1:0]     FailCnt,
   output logic [2:0]           o_dbg_state
);

   localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SHIFT_IN  = 3'd1,
      S_CAPTURE   = 3'd2,
      S_SHIFT_OUT = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  w_accept;
   logic                  w_last;
   logic [CHAIN_LEN-1:0]  r_shift;
   logic [CHAIN_LEN-1:0]  w_shift_nxt;
   logic [CHAIN_LEN-1:0]  r_exp;
   logic [CHAIN_LEN-1:0]  r_resp;
   logic [CHAIN_LEN-1:0]  w_resp_nxt;
   logic                  w_resp_eq;
   logic                  r_tms;
   logic                  r_tdi;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_pass;
   logic [CNT_W-1:0]      r_fail_cnt;

   assign w_last      = (r_cnt == LAST);
   assign w_shift_nxt = r_shift << 1;
   assign w_resp_nxt  = {r_resp[CHAIN_LEN-2:0], tdo};
   assign w_resp_eq   = (w_resp_nxt == r_exp);

   // Start/Busy handshake: Start is a request taken only on an IDLE edge; Busy marks the
   // cycles in which further requests are dropped (they are never queued).
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT_IN;
               w_cnt_nxt   = '0;
            end
         end
         S_SHIFT_IN: begin
            if (w_last) begin
               w_state_nxt = S_CAPTURE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_CAPTURE: begin
            w_state_nxt = S_SHIFT_OUT;
            w_cnt_nxt   = '0;
         end
         S_SHIFT_OUT: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_tms      <= 1'b0;
         r_tdi      <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_shift    <= '0;
         r_exp      <= '0;
         r_resp     <= '0;
         r_pass     <= 1'b0;
         r_fail_cnt <= '0;
      end else begin
         r_tms  <= (w_state_nxt == S_SHIFT_IN) || (w_state_nxt == S_SHIFT_OUT);
         r_busy <= (w_state_nxt == S_SHIFT_IN) || (w_state_nxt == S_CAPTURE) ||
                   (w_state_nxt == S_SHIFT_OUT);
         r_done <= (w_state_nxt == S_DONE);

         if (w_accept) begin
            r_tdi <= Pattern[CHAIN_LEN-1];
         end else if (r_state == S_SHIFT_IN && !w_last) begin
            r_tdi <= w_shift_nxt[CHAIN_LEN-1];
         end else begin
            r_tdi <= 1'b0;
         end

         if (w_accept) begin
            r_shift <= Pattern;
            r_exp   <= Expect;
            r_pass  <= 1'b0;
         end else if (r_state == S_SHIFT_IN) begin
            r_shift <= w_shift_nxt;
         end

         // tdo is sampled before this edge's shift lands, so the first bit becomes the MSB.
         if (r_state == S_SHIFT_OUT) begin
            r_resp <= w_resp_nxt;
            if (w_last) begin
               r_pass <= w_resp_eq;
               if (!w_resp_eq && (r_fail_cnt != {CNT_W{1'b1}})) begin
                  r_fail_cnt <= r_fail_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign tms         = r_tms;
   assign tdi         = r_tdi;
   assign Busy        = r_busy;
   assign Done        = r_done;
   assign Response    = r_resp;
   assign Pass        = r_pass;
   assign FailCnt     = r_fail_cnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_scan_pattern_sequencer.sv
// Bench for scan_pattern_sequencer: two instances (8-bit and 2-bit failure counters), each
// driving a 3-flop chain model whose capture loads the inverse of every flop.
module tb_scan_pattern_sequencer;

   logic       Clk;
   logic       Clr;
   logic       Start;
   logic [2:0] Pattern;
   logic [2:0] Expect;

   logic       tdo_a, tms_a, tdi_a, busy_a, done_a, pass_a;
   logic [2:0] resp_a, st_a;
   logic [7:0] fcnt_a;
   logic       tdo_b, tms_b, tdi_b, busy_b, done_b, pass_b;
   logic [2:0] resp_b, st_b;
   logic [1:0] fcnt_b;

   logic [2:0] chain_a = '0;
   logic [2:0] chain_b = '0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] pat;
      logic [2:0] expw;
      bit         do_chg;
      logic [2:0] chg_pat;
      bit         pulse_busy;
      logic [2:0] resp;
      bit         pass;
      logic [7:0] fa;
      logic [1:0] fb;
   } vec_t;

   vec_t vecs[7];

   scan_pattern_sequencer #(.CHAIN_LEN(3), .CNT_W(8)) u_dut_a (
      .Clk(Clk), .Clr(Clr), .Start(Start), .Pattern(Pattern), .Expect(Expect),
      .tdo(tdo_a), .tms(tms_a), .tdi(tdi_a), .Busy(busy_a), .Done(done_a),
      .Response(resp_a), .Pass(pass_a), .FailCnt(fcnt_a), .o_dbg_state(st_a)
   );

   scan_pattern_sequencer #(.CHAIN_LEN(3), .CNT_W(2)) u_dut_b (
      .Clk(Clk), .Clr(Clr), .Start(Start), .Pattern(Pattern), .Expect(Expect),
      .tdo(tdo_b), .tms(tms_b), .tdi(tdi_b), .Busy(busy_b), .Done(done_b),
      .Response(resp_b), .Pass(pass_b), .FailCnt(fcnt_b), .o_dbg_state(st_b)
   );

   // Clock / chain models
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   assign tdo_a = chain_a[2];
   assign tdo_b = chain_b[2];

   always @(posedge Clk) begin
      if (tms_a) chain_a <= {chain_a[1:0], tdi_a};
      else       chain_a <= ~chain_a;
      if (tms_b) chain_b <= {chain_b[1:0], tdi_b};
      else       chain_b <= ~chain_b;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tms"},   tms_a,   0);
      chk({tag, "_tdi"},   tdi_a,   0);
      chk({tag, "_busy"},  busy_a,  0);
      chk({tag, "_done"},  done_a,  0);
      chk({tag, "_resp"},  resp_a,  0);
      chk({tag, "_pass"},  pass_a,  0);
      chk({tag, "_fcnt_a"}, fcnt_a, 0);
      chk({tag, "_fcnt_b"}, fcnt_b, 0);
      chk({tag, "_state"}, st_a,    0);
   endtask

   // One full run starting from IDLE; Start is sampled by the first edge (edge 0).
   task automatic run_vec(input vec_t v);
      logic [8:0] obs_tms, obs_tdi, obs_busy, obs_done;
      logic [8:0] exp_tdi;
      obs_tms = '0; obs_tdi = '0; obs_busy = '0; obs_done = '0;
      exp_tdi = '0;
      exp_tdi[1] = v.pat[2];
      exp_tdi[2] = v.pat[1];
      exp_tdi[3] = v.pat[0];
      Pattern = v.pat;
      Expect  = v.expw;
      Start   = 1'b1;
      @(posedge Clk);
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) @(posedge Clk);
         #1;
         Start = (v.pulse_busy && (k == 2 || k == 5));
         if (v.do_chg && k == 2) Pattern = v.chg_pat;
         obs_tms[k]  = tms_a;
         obs_tdi[k]  = tdi_a;
         obs_busy[k] = busy_a;
         obs_done[k] = done_a;
         if (k == 1) chk("pass_cleared_on_accept", pass_a, 0);
         if (k == 4) chk("state_capture", st_a, 3'd2);
         if (k == 8) begin
            chk("response_a", resp_a, v.resp);
            chk("response_b", resp_b, v.resp);
            chk("pass_a",     pass_a, v.pass);
            chk("failcnt_a",  fcnt_a, v.fa);
            chk("failcnt_b",  fcnt_b, v.fb);
         end
      end
      Start = 1'b0;
      chk("tms_seq",  obs_tms,  9'b0_1110_1110);
      chk("tdi_seq",  obs_tdi,  exp_tdi);
      chk("busy_seq", obs_busy, 9'b0_1111_1110);
      chk("done_seq", obs_done, 9'b1_0000_0000);
      @(posedge Clk); #1;
      chk("idle_after_done_busy", busy_a, 0);
      chk("idle_after_done_done", done_a, 0);
      chk("idle_after_done_state", st_a, 0);
      if (v.pulse_busy) begin
         @(posedge Clk); #1;
         chk("no_queued_start_busy", busy_a, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_seen;
      vecs[0] = '{3'b101, 3'b010, 0, 3'b000, 0, 3'b010, 1, 8'd0, 2'd0};
      vecs[1] = '{3'b000, 3'b000, 0, 3'b000, 0, 3'b111, 0, 8'd1, 2'd1};
      vecs[2] = '{3'b000, 3'b000, 0, 3'b000, 1, 3'b111, 0, 8'd2, 2'd2};
      vecs[3] = '{3'b000, 3'b000, 0, 3'b000, 0, 3'b111, 0, 8'd3, 2'd3};
      vecs[4] = '{3'b110, 3'b001, 1, 3'b001, 0, 3'b001, 1, 8'd3, 2'd3};
      vecs[5] = '{3'b011, 3'b000, 0, 3'b000, 0, 3'b100, 0, 8'd4, 2'd3};
      vecs[6] = '{3'b111, 3'b111, 0, 3'b000, 0, 3'b000, 0, 8'd5, 2'd3};

      Clr = 1'b1; Start = 1'b0; Pattern = '0; Expect = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk_reset_outputs("reset");
      #4 Clr = 1'b0;
      @(posedge Clk); #1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Start held high: second run's SHIFT_IN begins in cycle 10.
      Pattern = 3'b101; Expect = 3'b010; Start = 1'b1;
      @(posedge Clk);
      for (int k = 1; k <= 10; k++) begin
         if (k > 1) @(posedge Clk);
         #1;
         if (k == 8) chk("held_done_c8", done_a, 1);
         if (k == 9) begin
            chk("held_c9_tms",   tms_a,  0);
            chk("held_c9_busy",  busy_a, 0);
            chk("held_c9_state", st_a,   0);
         end
         if (k == 10) begin
            chk("held_c10_tms",   tms_a,  1);
            chk("held_c10_busy",  busy_a, 1);
            chk("held_c10_state", st_a,   3'd1);
         end
      end
      Start = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 20 && done_seen == 0; k++) begin
         @(posedge Clk); #1;
         if (done_a) done_seen = 1;
      end
      chk("held_second_done", done_seen, 1);
      chk("held_second_pass", pass_a, 1);
      chk("held_second_fcnt", fcnt_a, 8'd5);
      @(posedge Clk); #1;

      // Asynchronous clear in the middle of SHIFT_OUT (cycle 6).
      Pattern = 3'b000; Expect = 3'b000; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      repeat (5) @(posedge Clk);
      #1;
      chk("pre_clr_state", st_a, 3'd3);
      #2 Clr = 1'b1;
      #1;
      chk_reset_outputs("midrun_clr");
      #3 Clr = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge Clk); #1;
         if (done_a || busy_a) done_seen++;
      end
      chk("no_done_after_clr", done_seen, 0);
      chk("fcnt_after_clr", fcnt_a, 0);

      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
